// File: rtl/rptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// rptr_empty_ctrl
//
// Read-domain pointer and status controller for a dual-clock FIFO that
// exchanges Gray-coded pointers between clock domains.
//
// The block keeps a binary read pointer (rbin) with one extra MSB so that
// "full" and "empty" are distinct, and a registered Gray copy of it (rptr).
// The Gray copy is handed to the write domain's synchroniser. The write
// pointer arrives here already synchronised into rclk (rq2_wptr). The block
// compares and subtracts the two pointers to produce the registered empty,
// almost-empty and fill-level status.
//
// Handshake: rinc is a read request. rempty == 0 acts as "ready", and data
// at raddr is valid while rempty == 0. A word is consumed on the rclk edge
// where rinc == 1 and rempty == 0. A request made while rempty == 1 is
// dropped: the pointer stays put and runderflow pulses for one cycle.
//
// Parameters
//   ADDRSIZE  RAM address width. Depth is 2**ADDRSIZE. Pointers are
//             ADDRSIZE+1 bits wide.
//   AE_LEVEL  ralmost_empty asserts when the level is <= AE_LEVEL.
//
// Ports
//   rclk           in   read-domain clock
//   rrst_n         in   asynchronous active-low reset (released on rclk)
//   rinc           in   read request
//   rq2_wptr       in   Gray write pointer, already synchronised into rclk
//   raddr          out  RAM read address (low bits of the binary pointer)
//   rptr           out  registered Gray read pointer, to the write side
//   rempty         out  registered empty flag
//   ralmost_empty  out  registered level <= AE_LEVEL flag
//   rlevel         out  registered number of readable entries
//   runderflow     out  one-cycle pulse when rinc is seen while empty
// ---------------------------------------------------------------------------
module rptr_empty_ctrl #(
    parameter int ADDRSIZE = 4,
    parameter int AE_LEVEL = 1
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    localparam logic [ADDRSIZE:0] AE_LVL = (ADDRSIZE + 1)'(AE_LEVEL);

    // Registered state
    logic [ADDRSIZE:0] rbin_q,          rbin_d;
    logic [ADDRSIZE:0] rptr_q,          rptr_d;
    logic              rempty_q,        rempty_d;
    logic              ralmost_empty_q, ralmost_empty_d;
    logic [ADDRSIZE:0] rlevel_q,        rlevel_d;
    logic              runderflow_q,    runderflow_d;

    // Combinational helpers
    logic              rd_en;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] level_next;

    // Gray to binary conversion: each binary bit is the XOR of all Gray
    // bits at or above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    always_comb begin
        rd_en  = rinc & ~rempty_q;
        rbin_d = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
        rptr_d = (rbin_d >> 1) ^ rbin_d;

        // The flags are computed from the post-read pointer. That way empty
        // asserts on the same edge that consumes the last word. The full
        // pointer width is used, so this stays correct when rq2_wptr jumps
        // by several entries in one cycle.
        level_next      = wbin_s - rbin_d;
        rempty_d        = (rptr_d == rq2_wptr);
        ralmost_empty_d = (level_next <= AE_LVL);
        rlevel_d        = level_next;
        runderflow_d    = rinc & rempty_q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rlevel_q        <= '0;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rlevel_q        <= rlevel_d;
            runderflow_q    <= runderflow_d;
        end
    end

    // raddr is taken straight from the register, with no logic after the flop.
    assign raddr         = rbin_q[ADDRSIZE-1:0];
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runderflow_q;

endmodule
